// File: rtl/ws2812b_pkg.sv
// Shared constants for the WS2812B transmitter/receiver pair: default
// 100 MHz wire timing, counter widths and the receiver state encoding.
package ws2812b_pkg;

   // Transmitter wire timing in 100 MHz cycles
   localparam int T0H      = 40;
   localparam int T1H      = 80;
   localparam int BIT_CYC  = 125;
   localparam int GAP_CYC  = 28000;

   localparam int GRB_BITS = 24;

   // Receiver counter widths (high counter saturates at 127, low at 32767)
   localparam int HI_CNT_W  = 7;
   localparam int LO_CNT_W  = 15;
   localparam int BIT_CNT_W = 5;

   // Receiver state encoding
   localparam logic [2:0] ST_SYNC = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_HIGH = 3'd2;
   localparam logic [2:0] ST_LOW  = 3'd3;
   localparam logic [2:0] ST_PASS = 3'd4;

endpackage

// File: rtl/nzr_bit_decoder.sv
// Line front end: synchronizes dataIn, measures high/low run lengths on the
// synchronized line and flags decoded bits, width violations and reset gaps.
// Counts track the line continuously; the FSM decides which events matter.
module nzr_bit_decoder import ws2812b_pkg::*; #(
   parameter int HIGH_MIN  = 20,
   parameter int T1_MIN    = 60,
   parameter int HIGH_MAX  = 100,
   parameter int RESET_CYC = 20000
) (
   input  logic clk,
   input  logic reset,
   input  logic dataIn,
   output logic dinS,
   output logic bitValid,
   output logic bitVal,
   output logic glitch,
   output logic tooLong,
   output logic gap
);

   localparam logic [HI_CNT_W-1:0] HMIN = HI_CNT_W'(HIGH_MIN);
   localparam logic [HI_CNT_W-1:0] T1M  = HI_CNT_W'(T1_MIN);
   localparam logic [HI_CNT_W-1:0] HMAX = HI_CNT_W'(HIGH_MAX);
   localparam logic [LO_CNT_W-1:0] RCYC = LO_CNT_W'(RESET_CYC);

   logic                sync1, dinPrev, rise, fall;
   logic [HI_CNT_W-1:0] hiCnt, hiNext;
   logic [LO_CNT_W-1:0] loCnt, loNext;

   // Synchronizer, edge history and run-length counters
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         dinS    <= 1'b0;
         dinPrev <= 1'b0;
         hiCnt   <= '0;
         loCnt   <= '0;
      end else begin
         sync1   <= dataIn;
         dinS    <= sync1;
         dinPrev <= dinS;
         hiCnt   <= hiNext;
         loCnt   <= loNext;
      end
   end

   // Next counts: hiNext is the length of the high run including this cycle,
   // so at a falling edge hiCnt holds the exact pulse width.
   always_comb begin
      rise   = dinS & ~dinPrev;
      fall   = ~dinS & dinPrev;
      hiNext = hiCnt;
      if (rise)
         hiNext = HI_CNT_W'(1);
      else if (dinS && hiCnt != '1)
         hiNext = hiCnt + HI_CNT_W'(1);
      loNext = loCnt;
      if (dinS)
         loNext = '0;
      else if (loCnt != '1)
         loNext = loCnt + LO_CNT_W'(1);
   end

   assign glitch   = fall && (hiCnt < HMIN);
   assign bitValid = fall && !glitch;
   assign bitVal   = (hiCnt >= T1M);
   // Fires in the HIGH_MAX-th high cycle, so a pulse of exactly HIGH_MAX is illegal
   assign tooLong  = dinS && (hiNext == HMAX);
   // Single-cycle event on the RESET_CYC-th consecutive low cycle
   assign gap      = !dinS && (loNext == RCYC);

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B pixel model: decodes the first 24-bit GRB word of each frame,
// forwards the rest of the frame on dataOut and latches the captured colour
// into grb when the reset gap ends the frame.
module ws2812b_receiver import ws2812b_pkg::*; #(
   parameter int HIGH_MIN  = 20,
   parameter int T1_MIN    = 60,
   parameter int HIGH_MAX  = 100,
   parameter int RESET_CYC = 20000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                dataIn,
   output logic                dataOut,
   output logic [GRB_BITS-1:0] grb,
   output logic                latch,
   output logic                bitErr
);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(GRB_BITS - 1);

   logic                 dinS, bitValid, bitVal, glitch, tooLong, gap;
   logic [2:0]           state;
   logic [BIT_CNT_W-1:0] bitCnt;
   logic [GRB_BITS-1:0]  shiftReg, pending, shiftNext;

   nzr_bit_decoder #(
      .HIGH_MIN  (HIGH_MIN),
      .T1_MIN    (T1_MIN),
      .HIGH_MAX  (HIGH_MAX),
      .RESET_CYC (RESET_CYC)
   ) uDec (
      .clk      (clk),
      .reset    (reset),
      .dataIn   (dataIn),
      .dinS     (dinS),
      .bitValid (bitValid),
      .bitVal   (bitVal),
      .glitch   (glitch),
      .tooLong  (tooLong),
      .gap      (gap)
   );

   assign shiftNext = {shiftReg[GRB_BITS-2:0], bitVal};

   // Frame FSM: word capture, error recovery via SYNC, pass-through and latch.
   // IDLE/LOW are only entered with the line low, so a high dinS there is a rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_SYNC;
         bitCnt   <= '0;
         shiftReg <= '0;
         pending  <= '0;
         grb      <= '0;
         latch    <= 1'b0;
         bitErr   <= 1'b0;
      end else begin
         latch  <= 1'b0;
         bitErr <= 1'b0;
         case (state)
            ST_SYNC: begin
               bitCnt <= '0;
               if (gap) state <= ST_IDLE;
            end
            ST_IDLE: begin
               bitCnt <= '0;
               if (dinS) state <= ST_HIGH;
            end
            ST_HIGH: begin
               if (tooLong || glitch) begin
                  bitErr <= 1'b1;
                  bitCnt <= '0;
                  state  <= ST_SYNC;
               end else if (bitValid) begin
                  shiftReg <= shiftNext;
                  bitCnt   <= bitCnt + BIT_CNT_W'(1);
                  if (bitCnt == LAST_BIT) begin
                     pending <= shiftNext;
                     state   <= ST_PASS;
                  end else begin
                     state   <= ST_LOW;
                  end
               end
            end
            ST_LOW: begin
               if (dinS)
                  state <= ST_HIGH;
               else if (gap)
                  state <= ST_IDLE;
            end
            ST_PASS: begin
               if (gap) begin
                  grb   <= pending;
                  latch <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_SYNC;
         endcase
      end
   end

   // Forwarding taps the synchronized line so edges keep their widths
   assign dataOut = (state == ST_PASS) && dinS;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Bench for ws2812b_receiver: table of frames, hand-written error/reset
// sequences and random frames checked against a frame-level pixel model.
// The reset gap is scaled down so the whole run stays short.
module tb_ws2812b_receiver;

   localparam int HMIN  = 20;
   localparam int T1MIN = 60;
   localparam int HMAX  = 100;
   localparam int RCYC  = 600;
   localparam int GAP   = 840;
   localparam int PER   = 125;
   localparam int T0    = 40;
   localparam int T1    = 80;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dataIn = 1'b0;
   logic        dataOut, latch, bitErr;
   logic [23:0] grb;

   ws2812b_receiver #(
      .HIGH_MIN (HMIN), .T1_MIN (T1MIN), .HIGH_MAX (HMAX), .RESET_CYC (RCYC)
   ) dut (
      .clk (clk), .reset (reset), .dataIn (dataIn),
      .dataOut (dataOut), .grb (grb), .latch (latch), .bitErr (bitErr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int latchCnt = 0, errCnt = 0, outMis = 0, lastLatchCyc = -1, lastErrCyc = -1;
   int lastRise = 0, lastFall = 0;
   bit driveExp = 1'b0, prevLvl = 1'b0, d1 = 1'b0, d2 = 1'b0;

   // Frame-level model state
   bit          mSynced = 1'b0;
   logic [23:0] mGrb = '0;
   int          hw[64], lw[64];

   typedef struct {
      int          n;
      logic [47:0] data;
      bit          expLatch;
      logic [23:0] expGrb;
   } vec_t;
   vec_t tbl[5];

   // Monitor: event counts and dataOut against the input delayed two cycles
   initial forever begin
      @(negedge clk);
      if (latch)  begin latchCnt++; lastLatchCyc = cyc; end
      if (bitErr) begin errCnt++;   lastErrCyc   = cyc; end
      if (dataOut !== d2) outMis++;
      if (reset) begin d1 = 1'b0; d2 = 1'b0; end
      else begin d2 = d1; d1 = driveExp; end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit lvl, input int n, input bit ex);
      repeat (n) begin
         @(posedge clk); #1;
         dataIn   = lvl;
         driveExp = ex & lvl;
         if (lvl && !prevLvl) lastRise = cyc;
         if (!lvl && prevLvl) lastFall = cyc;
         prevLvl = lvl;
      end
   endtask

   task automatic loadBits(input logic [47:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         hw[i] = d[47-i] ? T1 : T0;
         lw[i] = PER - hw[i];
      end
   endtask

   // Plays hw/lw pulses then a gap; the model decides error, latch and forwarding
   task automatic doFrame(input string nm, input int n, input bit useTbl,
                          input bit tL, input logic [23:0] tG);
      int l0, e0, m0, errIdx, errCyc;
      bit expE, expL, exL;
      logic [23:0] w, exG;
      l0 = latchCnt; e0 = errCnt; m0 = outMis; errIdx = -1; errCyc = 0; w = '0;
      for (int i = 0; i < n && i < 24; i++) begin
         if (errIdx < 0 && (hw[i] < HMIN || hw[i] >= HMAX)) errIdx = i;
         w = {w[22:0], (hw[i] >= T1MIN) ? 1'b1 : 1'b0};
      end
      expE = mSynced && errIdx >= 0;
      expL = mSynced && !expE && n >= 24;
      for (int i = 0; i < n; i++) begin
         drive(1'b1, hw[i], expL && i >= 24);
         if (expE && i == errIdx && hw[i] >= HMAX) errCyc = lastRise + 2 + HMAX;
         drive(1'b0, lw[i], 1'b0);
         if (expE && i == errIdx && hw[i] < HMIN) errCyc = lastFall + 3;
      end
      drive(1'b0, GAP, 1'b0);
      if (expL) mGrb = w;
      mSynced = 1'b1;
      exL = useTbl ? tL : expL;
      exG = useTbl ? tG : mGrb;
      chk({nm, "_latchN"}, latchCnt - l0, 32'(exL));
      if (exL) chk({nm, "_latchT"}, lastLatchCyc, lastFall + 2 + RCYC);
      chk({nm, "_grb"}, grb, exG);
      chk({nm, "_errN"}, errCnt - e0, 32'(expE));
      if (expE) chk({nm, "_errT"}, lastErrCyc, errCyc);
      chk({nm, "_dOut"}, outMis - m0, 0);
   endtask

   initial begin
      int l0, e0, m0, n, idx;
      tbl[0] = '{24, 48'h5A5A5A_000000, 1'b0, 24'h000000};
      tbl[1] = '{24, 48'hA5C33C_000000, 1'b1, 24'hA5C33C};
      tbl[2] = '{48, 48'h112233_445566, 1'b1, 24'h112233};
      tbl[3] = '{12, 48'hABC000_000000, 1'b0, 24'h112233};
      tbl[4] = '{24, 48'h00FF81_000000, 1'b1, 24'h00FF81};

      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_dataOut", dataOut, 0);
      chk("rst_grb", grb, 0);
      chk("rst_latch", latch, 0);
      chk("rst_bitErr", bitErr, 0);

      // Table: first row has no preceding gap, so it must be ignored
      for (int t = 0; t < 5; t++) begin
         loadBits(tbl[t].data, tbl[t].n);
         doFrame($sformatf("tbl%0d", t), tbl[t].n, 1'b1, tbl[t].expLatch, tbl[t].expGrb);
      end

      // Short glitch as the first bit, later bits ignored until the gap
      loadBits({24'h3C3C3C, 24'hF0F0F0}, 30);
      hw[0] = 10; lw[0] = PER - 10;
      doFrame("glitch", 30, 1'b0, 1'b0, '0);

      // High pulse of exactly HIGH_MAX inside the word
      loadBits({24'h0F0F0F, 24'h0}, 24);
      hw[3] = HMAX; lw[3] = 30;
      doFrame("tooLong", 24, 1'b0, 1'b0, '0);

      // Width boundaries: HIGH_MIN, T1_MIN-1 -> 0; T1_MIN, HIGH_MAX-1 -> 1
      for (int i = 0; i < 24; i++) begin
         case (i % 4)
            0: hw[i] = HMIN;
            1: hw[i] = T1MIN - 1;
            2: hw[i] = T1MIN;
            default: hw[i] = HMAX - 1;
         endcase
         lw[i] = 40;
      end
      doFrame("bound", 24, 1'b0, 1'b0, '0);
      chk("bound_const", grb, 24'h333333);

      // Reset during the high of bit 30 of a forwarded frame
      loadBits({24'h123456, 24'h789ABC}, 48);
      l0 = latchCnt; e0 = errCnt; m0 = outMis;
      for (int i = 0; i < 29; i++) begin
         drive(1'b1, hw[i], i >= 24);
         drive(1'b0, lw[i], 1'b0);
      end
      drive(1'b1, 30, 1'b1);
      @(posedge clk); #1;
      reset = 1'b1; driveExp = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstMid_dataOut", dataOut, 0);
      chk("rstMid_grb", grb, 0);
      mSynced = 1'b0; mGrb = '0;
      drive(1'b1, 20, 1'b0);
      drive(1'b0, lw[29], 1'b0);
      for (int i = 30; i < 48; i++) begin
         drive(1'b1, hw[i], 1'b0);
         drive(1'b0, lw[i], 1'b0);
      end
      drive(1'b0, GAP, 1'b0);
      mSynced = 1'b1;
      chk("rstMid_latchN", latchCnt - l0, 0);
      chk("rstMid_grb2", grb, 0);
      chk("rstMid_errN", errCnt - e0, 0);
      chk("rstMid_dOut", outMis - m0, 0);

      // Random frames; odd iterations carry one illegal pulse somewhere
      for (int r = 0; r < 4; r++) begin
         n = (r == 0) ? $urandom_range(24, 36) : $urandom_range(12, 36);
         for (int i = 0; i < n; i++) begin
            hw[i] = $urandom_range(HMIN, HMAX - 1);
            lw[i] = $urandom_range(5, 60);
         end
         if (r % 2 == 1) begin
            idx = $urandom_range(0, n - 1);
            hw[idx] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, HMIN - 1)
                                                  : $urandom_range(HMAX, HMAX + 10);
         end
         doFrame($sformatf("rnd%0d", r), n, 1'b0, 1'b0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
